// File: rtl/core_alu_arb_pkg.sv
// rtl/core_alu_arb_pkg.sv - shared core encodings: ALU ops, branch conditions, slot FSM states
// Purpose: single home for the op/condition/state encodings used by core_alu and core_alu_arb.
// Ports: none (package).
package core_alu_arb_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_op_e;

  // Bit 2 enables the branch; bits [1:0] select the comparison.
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_EQ   = 3'b100,
    BR_NE   = 3'b101,
    BR_LT   = 3'b110,
    BR_GE   = 3'b111
  } brnch_cnd_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - combinational 32-bit ALU with branch comparator
// Purpose: computes result and branch outcome of one operation.
// Ports: alu_op_i (4), brnch_cnd_i (3), src1_i/src2_i (32) in;
//        result_o (32), brnch_taken_o (1) out.
module core_alu
  import core_alu_arb_pkg::*;
(
  input  logic [3:0]  alu_op_i,
  input  logic [2:0]  brnch_cnd_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [31:0] result_o,
  output logic        brnch_taken_o
);

  always_comb begin
    result_o = 32'h0;
    case (alu_op_i)
      ALU_ADD:  result_o = src1_i + src2_i;
      ALU_SUB:  result_o = src1_i - src2_i;
      ALU_AND:  result_o = src1_i & src2_i;
      ALU_OR:   result_o = src1_i | src2_i;
      ALU_XOR:  result_o = src1_i ^ src2_i;
      ALU_SLL:  result_o = src1_i << src2_i[4:0];
      ALU_SRL:  result_o = src1_i >> src2_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(src1_i) >>> src2_i[4:0]);
      ALU_SLT:  result_o = {31'h0, $signed(src1_i) < $signed(src2_i)};
      ALU_SLTU: result_o = {31'h0, src1_i < src2_i};
      default:  result_o = 32'h0;
    endcase
  end

  // Codes with the enable bit clear fall into default, so taken stays 0.
  always_comb begin
    brnch_taken_o = 1'b0;
    case (brnch_cnd_i)
      BR_EQ:   brnch_taken_o = (src1_i == src2_i);
      BR_NE:   brnch_taken_o = (src1_i != src2_i);
      BR_LT:   brnch_taken_o = ($signed(src1_i) < $signed(src2_i));
      BR_GE:   brnch_taken_o = !($signed(src1_i) < $signed(src2_i));
      default: brnch_taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_alu_arb.sv
// rtl/core_alu_arb.sv - two-requester round-robin arbiter in front of one ALU with a one-entry response slot
// Purpose: grants one requester per cycle into a registered response slot.
// Ports: clk, rst (sync, active-high);
//        req0_*/req1_*: val/rdy handshake, alu_op, brnch_cnd, src1, src2, tag;
//        rsp_*: val/rdy handshake, id, tag, result, brnch_taken.
module core_alu_arb
  import core_alu_arb_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic [3:0]       req0_alu_op,
  input  logic [2:0]       req0_brnch_cnd,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic [3:0]       req1_alu_op,
  input  logic [2:0]       req1_brnch_cnd,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_val,
  input  logic             rsp_rdy,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_brnch_taken
);

  slot_state_e      state_q;
  logic             ptr_q;
  logic [31:0]      result_q;
  logic             taken_q;
  logic             id_q;
  logic [TAG_W-1:0] tag_q;

  logic             slot_free;
  logic             gnt0;
  logic             gnt1;
  logic             gnt_any;
  logic [3:0]       mux_op;
  logic [2:0]       mux_cnd;
  logic [31:0]      mux_src1;
  logic [31:0]      mux_src2;
  logic [31:0]      result_d;
  logic             taken_d;
  logic             id_d;
  logic [TAG_W-1:0] tag_d;

  // Reset is folded in here so neither requester sees rdy while rst is held.
  assign slot_free = !rst && ((state_q == SLOT_EMPTY) || rsp_rdy);

  // Pointer only matters when both are valid.
  assign gnt0    = slot_free && req0_val && (!req1_val || !ptr_q);
  assign gnt1    = slot_free && req1_val && (!req0_val ||  ptr_q);
  assign gnt_any = gnt0 || gnt1;

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;

  assign id_d     = gnt1;
  assign mux_op   = gnt1 ? req1_alu_op    : req0_alu_op;
  assign mux_cnd  = gnt1 ? req1_brnch_cnd : req0_brnch_cnd;
  assign mux_src1 = gnt1 ? req1_src1      : req0_src1;
  assign mux_src2 = gnt1 ? req1_src2      : req0_src2;
  assign tag_d    = gnt1 ? req1_tag       : req0_tag;

  core_alu u_alu (
    .alu_op_i      (mux_op),
    .brnch_cnd_i   (mux_cnd),
    .src1_i        (mux_src1),
    .src2_i        (mux_src2),
    .result_o      (result_d),
    .brnch_taken_o (taken_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      ptr_q    <= 1'b0;
      result_q <= 32'h0;
      taken_q  <= 1'b0;
      id_q     <= 1'b0;
      tag_q    <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: if (gnt_any) state_q <= SLOT_FULL;
        SLOT_FULL:  if (!gnt_any && rsp_rdy) state_q <= SLOT_EMPTY;
      endcase
      // Slot contents only change on a grant, which keeps them stable under stall.
      if (gnt_any) begin
        result_q <= result_d;
        taken_q  <= taken_d;
        id_q     <= id_d;
        tag_q    <= tag_d;
        ptr_q    <= !id_d;
      end
    end
  end

  assign rsp_val         = (state_q == SLOT_FULL);
  assign rsp_id          = id_q;
  assign rsp_tag         = tag_q;
  assign rsp_result      = result_q;
  assign rsp_brnch_taken = taken_q;

endmodule
